// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/packer slice: receiver FSM state
// type and default line/word constants.
package uart_pkg;

  localparam int unsigned CLOCKS_PER_PULSE = 434;
  localparam int unsigned BITS_PER_WORD    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_word.sv
// UART word receiver: rx synchronizer, frame FSM and bit counters.
// Optional even-parity bit enabled by macro UART_RX_PARITY_EN.
module uart_rx_word #(
  parameter int unsigned CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = uart_pkg::BITS_PER_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] word,
  output logic                     word_ok,
  output logic                     word_err
);
  import uart_pkg::*;

  localparam int unsigned CW = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

  rx_state_e              state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] shreg_q, shreg_d;
  logic                   par_err_q, par_err_d;
  logic                   ok_q, ok_d;
  logic                   err_q, err_d;
  logic                   rx_s;
  logic                   sample_pt;

  assign rx_s      = sync2_q;
  assign sample_pt = (cnt_q == CW'(CLOCKS_PER_PULSE - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        par_err_d = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (sample_pt) begin
          cnt_d          = '0;
          shreg_d[bit_q] = rx_s;
          if (bit_q == BW'(BITS_PER_WORD - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (sample_pt) begin
          cnt_d     = '0;
          par_err_d = (^shreg_q) ^ rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (sample_pt) begin
          cnt_d = '0;
          // parity and stop errors collapse into a single frame_err pulse
          if (rx_s && !par_err_q) ok_d = 1'b1;
          else                    err_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign word     = shreg_q;
  assign word_ok  = ok_q;
  assign word_err = err_q;

endmodule

// File: rtl/uart_rx_packer.sv
// Packs N_WORDS received UART words into one packet with a valid/ready output.
// Parity support selected by macro UART_RX_PARITY_EN (see uart_rx_word).
module uart_rx_packer #(
  parameter int unsigned CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = uart_pkg::BITS_PER_WORD,
  parameter int unsigned N_WORDS          = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx,
  output logic [N_WORDS*BITS_PER_WORD-1:0]   m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               frame_err,
  output logic                               overrun
);

  localparam int unsigned PW  = N_WORDS * BITS_PER_WORD;
  localparam int unsigned WCW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic [BITS_PER_WORD-1:0] word;
  logic                     word_ok;
  logic                     word_err;

  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [PW-1:0]  pack_q, pack_d;
  logic [PW-1:0]  m_data_q, m_data_d;
  logic           m_valid_q, m_valid_d;
  logic           overrun_q, overrun_d;
  logic           complete;
  logic           fire;

  uart_rx_word #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
    .BITS_PER_WORD    (BITS_PER_WORD)
  ) u_word (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .word     (word),
    .word_ok  (word_ok),
    .word_err (word_err)
  );

  assign fire     = m_valid_q && m_ready;
  assign complete = word_ok && (wcnt_q == WCW'(N_WORDS - 1));

  always_comb begin
    wcnt_d    = wcnt_q;
    pack_d    = pack_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = 1'b0;
    if (word_ok) begin
      pack_d[int'(wcnt_q) * BITS_PER_WORD +: BITS_PER_WORD] = word;
      wcnt_d = complete ? '0 : wcnt_q + WCW'(1);
    end
    // a packet completing on a handshake cycle replaces the one being consumed
    if (complete && (!m_valid_q || fire)) begin
      m_data_d  = pack_d;
      m_valid_d = 1'b1;
    end else if (complete) begin
      overrun_d = 1'b1;
    end else if (fire) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q    <= '0;
      pack_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      pack_q    <= pack_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = word_err;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer with CLOCKS_PER_PULSE=8, 8-bit words, 3 words/packet.
module tb_uart_rx_packer;

  localparam int unsigned CPP = 8;
  localparam int unsigned BPW = 8;
  localparam int unsigned NW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx;
  logic [NW*BPW-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              frame_err;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  int          fe_cnt   = 0;
  int          ov_cnt   = 0;
  int          rise_cnt = 0;
  int          hi_cnt   = 0;
  logic        valid_prev = 1'b0;
  logic [23:0] data_cap = '0;

  uart_rx_packer #(
    .CLOCKS_PER_PULSE (CPP),
    .BITS_PER_WORD    (BPW),
    .N_WORDS          (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (m_valid) begin
      hi_cnt++;
      data_cap = m_data;
    end
    if (m_valid && !valid_prev) rise_cnt++;
    valid_prev = m_valid;
  end

  task automatic line_bit(input logic v);
    rx = v;
    repeat (CPP) @(posedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    line_bit((^d) ^ par_flip);
`endif
    line_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 24'h0) begin errors++; $display("FAIL reset_m_data got=%h exp=000000", m_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_basic;
    int r0, h0, f0;
    r0 = rise_cnt; h0 = hi_cnt; f0 = fe_cnt;
    m_ready = 1'b1;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    idle(3 * CPP);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL basic_valid_rises got=%0d exp=1", rise_cnt - r0); end
    checks++; if (hi_cnt - h0 !== 1) begin errors++; $display("FAIL basic_valid_width got=%0d exp=1", hi_cnt - h0); end
    checks++; if (data_cap !== 24'h332211) begin errors++; $display("FAIL basic_data got=%h exp=332211", data_cap); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL basic_frame_err got=%0d exp=0", fe_cnt - f0); end
  endtask

  task automatic test_glitch;
    int r0, f0;
    r0 = rise_cnt; f0 = fe_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    idle(2 * CPP);
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(3 * CPP);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL glitch_valid_rises got=%0d exp=1", rise_cnt - r0); end
    checks++; if (data_cap !== 24'hFF5AA5) begin errors++; $display("FAIL glitch_data got=%h exp=FF5AA5", data_cap); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - f0); end
  endtask

  task automatic test_frame_err;
    int r0, f0;
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h01, 1'b0, 1'b0);
    idle(2 * CPP);
    send_frame(8'h02, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0);
    send_frame(8'h04, 1'b1, 1'b0);
    idle(3 * CPP);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL stop_frame_err got=%0d exp=1", fe_cnt - f0); end
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL stop_valid_rises got=%0d exp=1", rise_cnt - r0); end
    checks++; if (data_cap !== 24'h040302) begin errors++; $display("FAIL stop_data got=%h exp=040302", data_cap); end
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ov_cnt;
    m_ready = 1'b0;
    send_frame(8'h10, 1'b1, 1'b0);
    send_frame(8'h20, 1'b1, 1'b0);
    send_frame(8'h30, 1'b1, 1'b0);
    send_frame(8'h40, 1'b1, 1'b0);
    send_frame(8'h50, 1'b1, 1'b0);
    send_frame(8'h60, 1'b1, 1'b0);
    idle(3 * CPP);
    @(negedge clk);
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt - o0); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got=%b exp=1", m_valid); end
    checks++; if (m_data !== 24'h302010) begin errors++; $display("FAIL ovr_data_held got=%h exp=302010", m_data); end
    m_ready = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got=%b exp=0", m_valid); end
  endtask

  task automatic test_mid_reset;
    int r0;
    m_ready = 1'b1;
    send_frame(8'h77, 1'b1, 1'b0);
    send_frame(8'h88, 1'b1, 1'b0);
    line_bit(1'b0);
    line_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b exp=0", m_valid); end
    rst = 1'b0;
    idle(2 * CPP);
    r0 = rise_cnt;
    send_frame(8'h0A, 1'b1, 1'b0);
    send_frame(8'h0B, 1'b1, 1'b0);
    send_frame(8'h0C, 1'b1, 1'b0);
    idle(3 * CPP);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL mrst_valid_rises got=%0d exp=1", rise_cnt - r0); end
    checks++; if (data_cap !== 24'h0C0B0A) begin errors++; $display("FAIL mrst_data got=%h exp=0C0B0A", data_cap); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int r0, f0;
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h03, 1'b1, 1'b1);
    idle(2 * CPP);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL par_frame_err got=%0d exp=1", fe_cnt - f0); end
    send_frame(8'h03, 1'b1, 1'b0);
    send_frame(8'h04, 1'b1, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0);
    idle(3 * CPP);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL par_valid_rises got=%0d exp=1", rise_cnt - r0); end
    checks++; if (data_cap !== 24'h050403) begin errors++; $display("FAIL par_data got=%h exp=050403", data_cap); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
